// File: rtl/jx2_ex_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : jx2_ex_addsub_pipe
// Purpose  : Two-stage pipelined 64-bit add/subtract/compare unit for the Jx2
//            execute path.
//            Stage 1 latches the operands, conditions B (B or ~B) and forms
//            the carry-in.
//            Stage 2 runs a carry-select adder built from 16-bit blocks and
//            registers the result, compare flag and carry.
// Ports    : clock    - sole clock, rising edge
//            reset    - synchronous, active-high
//            exHold   - freezes both stages and the carry register
//            opValid  - issue strobe for opCmd/opValA/opValB
//            opCmd    - 000 NOP 001 ADD 010 SUB 011 ADC 100 SBB
//                       101 CMPEQ 110 CMPGT(signed) 111 CMPHI(unsigned)
//            opValA   - operand A (64 bits)
//            opValB   - operand B (64 bits)
//            resValid - result valid (stage 2)
//            resVal   - result; {63'b0, T} for compares
//            resT     - compare flag, 0 for arithmetic ops
//            resCarry - carry/borrow register value
// Config   : JX2_ALU_ADDCARRY_EN - enables ADC/SBB, the carry register and
//            stage-2 to stage-1 carry forwarding. When undefined, 011/100
//            behave as ADD/SUB and resCarry is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module jx2_ex_addsub_pipe (
  input  logic        clock,
  input  logic        reset,
  input  logic        exHold,
  input  logic        opValid,
  input  logic [2:0]  opCmd,
  input  logic [63:0] opValA,
  input  logic [63:0] opValB,
  output logic        resValid,
  output logic [63:0] resVal,
  output logic        resT,
  output logic        resCarry
);

  localparam logic [2:0] c_cmd_nop   = 3'b000;
  localparam logic [2:0] c_cmd_add   = 3'b001;
  localparam logic [2:0] c_cmd_sub   = 3'b010;
  localparam logic [2:0] c_cmd_adc   = 3'b011;
  localparam logic [2:0] c_cmd_sbb   = 3'b100;
  localparam logic [2:0] c_cmd_cmpeq = 3'b101;
  localparam logic [2:0] c_cmd_cmpgt = 3'b110;
  localparam logic [2:0] c_cmd_cmphi = 3'b111;

  // Stage 1 registers
  logic        s1_valid_q, s1_valid_d;
  logic [2:0]  s1_cmd_q,   s1_cmd_d;
  logic [63:0] s1_a_q,     s1_a_d;
  logic [63:0] s1_b_q,     s1_b_d;
  logic        s1_cin_q,   s1_cin_d;

  // Stage 2 (output) registers
  logic        res_valid_q, res_valid_d;
  logic [63:0] res_val_q,   res_val_d;
  logic        res_t_q,     res_t_d;

  // Carry register next value; also the forwarded carry for stage 1
  logic        carry_d;

  // --------------------------------------------------------------------------
  // Stage 2 adder: 16-bit blocks with precomputed +0 / +1 sums
  // --------------------------------------------------------------------------
  logic [16:0] w_blk_s0 [4];
  logic [16:0] w_blk_s1 [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_blk
    assign w_blk_s0[gi] = {1'b0, s1_a_q[gi*16 +: 16]} + {1'b0, s1_b_q[gi*16 +: 16]};
    assign w_blk_s1[gi] = {1'b0, s1_a_q[gi*16 +: 16]} + {1'b0, s1_b_q[gi*16 +: 16]} + 17'd1;
  end

  logic [63:0] w_sum;
  logic        w_c;
  logic        w_z;
  logic        w_n;
  logic        w_v;

  // Block carry ripples only through the select muxes
  always_comb begin
    logic w_blk_c;
    w_sum   = '0;
    w_blk_c = s1_cin_q;
    for (int i = 0; i < 4; i++) begin
      w_sum[i*16 +: 16] = w_blk_c ? w_blk_s1[i][15:0] : w_blk_s0[i][15:0];
      w_blk_c           = w_blk_c ? w_blk_s1[i][16]   : w_blk_s0[i][16];
    end
    w_c = w_blk_c;
  end

  assign w_z = (w_sum == 64'd0);
  assign w_n = w_sum[63];
  assign w_v = (s1_a_q[63] == s1_b_q[63]) && (w_n != s1_a_q[63]);

  // --------------------------------------------------------------------------
  // Carry register
  // --------------------------------------------------------------------------
`ifdef JX2_ALU_ADDCARRY_EN
  logic carry_q;

  // ADC stores the carry, SBB stores the borrow (inverted carry).
  always_comb begin
    carry_d = carry_q;
    if (!exHold && s1_valid_q) begin
      if (s1_cmd_q == c_cmd_adc) begin
        carry_d = w_c;
      end else if (s1_cmd_q == c_cmd_sbb) begin
        carry_d = !w_c;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

  assign resCarry = carry_q;
`else
  assign carry_d  = 1'b0;
  assign resCarry = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Stage 1: operand conditioning
  // --------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cmd_d   = s1_cmd_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_cin_d   = s1_cin_q;
    if (!exHold) begin
      s1_valid_d = opValid && (opCmd != c_cmd_nop);
      s1_cmd_d   = opCmd;
      s1_a_d     = opValA;
      s1_b_d     = opValB;
      s1_cin_d   = 1'b0;
      case (opCmd)
        c_cmd_sub, c_cmd_cmpeq, c_cmd_cmpgt, c_cmd_cmphi: begin
          s1_b_d   = ~opValB;
          s1_cin_d = 1'b1;
        end
        // carry_d is the post-edge carry value, so a back-to-back ADC/SBB
        // sees the carry produced by the op currently in stage 2.
        c_cmd_adc: begin
          s1_cin_d = carry_d;
        end
        c_cmd_sbb: begin
          s1_b_d   = ~opValB;
`ifdef JX2_ALU_ADDCARRY_EN
          s1_cin_d = !carry_d;
`else
          s1_cin_d = 1'b1;
`endif
        end
        default: begin
          s1_cin_d = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: result selection
  // --------------------------------------------------------------------------
  always_comb begin
    res_valid_d = res_valid_q;
    res_val_d   = res_val_q;
    res_t_d     = res_t_q;
    if (!exHold) begin
      res_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        case (s1_cmd_q)
          c_cmd_cmpeq: res_t_d = w_z;
          c_cmd_cmpgt: res_t_d = !w_z && (w_n == w_v);
          c_cmd_cmphi: res_t_d = w_c && !w_z;
          default:     res_t_d = 1'b0;
        endcase
        case (s1_cmd_q)
          c_cmd_cmpeq, c_cmd_cmpgt, c_cmd_cmphi: res_val_d = {63'd0, res_t_d};
          default:                               res_val_d = w_sum;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_cmd_q    <= c_cmd_nop;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_cin_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_val_q   <= '0;
      res_t_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cmd_q    <= s1_cmd_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_cin_q    <= s1_cin_d;
      res_valid_q <= res_valid_d;
      res_val_q   <= res_val_d;
      res_t_q     <= res_t_d;
    end
  end

  assign resValid = res_valid_q;
  assign resVal   = res_val_q;
  assign resT     = res_t_q;

endmodule
`default_nettype wire

// File: tb/tb_jx2_ex_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_jx2_ex_addsub_pipe
// Purpose  : Self-checking bench for jx2_ex_addsub_pipe: table of directed
//            vectors plus hand-written pipeline sequences (throughput, carry
//            chaining, hold, reset). Honours JX2_ALU_ADDCARRY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jx2_ex_addsub_pipe;

  localparam logic [2:0] c_nop   = 3'b000;
  localparam logic [2:0] c_add   = 3'b001;
  localparam logic [2:0] c_sub   = 3'b010;
  localparam logic [2:0] c_adc   = 3'b011;
  localparam logic [2:0] c_sbb   = 3'b100;
  localparam logic [2:0] c_cmpeq = 3'b101;
  localparam logic [2:0] c_cmpgt = 3'b110;
  localparam logic [2:0] c_cmphi = 3'b111;

  localparam logic [63:0] c_ones = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] c_min  = 64'h8000_0000_0000_0000;

  logic        clock;
  logic        reset;
  logic        exHold;
  logic        opValid;
  logic [2:0]  opCmd;
  logic [63:0] opValA;
  logic [63:0] opValB;
  logic        resValid;
  logic [63:0] resVal;
  logic        resT;
  logic        resCarry;

  int checks;
  int errors;

  jx2_ex_addsub_pipe dut (
    .clock    (clock),
    .reset    (reset),
    .exHold   (exHold),
    .opValid  (opValid),
    .opCmd    (opCmd),
    .opValA   (opValA),
    .opValB   (opValB),
    .resValid (resValid),
    .resVal   (resVal),
    .resT     (resT),
    .resCarry (resCarry)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  cmd;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] val;
    logic        t;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] cmd, input logic [63:0] a, input logic [63:0] b);
    opValid = v;
    opCmd   = cmd;
    opValA  = a;
    opValB  = b;
  endtask

  logic [63:0] exp_r1, exp_r2, exp_c1;

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    exHold  = 1'b0;
    drive(1'b0, c_nop, 64'd0, 64'd0);

    vecs[0]  = '{c_add,   c_ones, 64'd1, 64'd0, 1'b0};
    vecs[1]  = '{c_sub,   64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[2]  = '{c_cmpgt, 64'd5, 64'd7, 64'd0, 1'b0};
    vecs[3]  = '{c_cmphi, 64'd7, 64'd5, 64'd1, 1'b1};
    vecs[4]  = '{c_cmpgt, c_min, 64'd1, 64'd0, 1'b0};
    vecs[5]  = '{c_cmpeq, 64'd42, 64'd42, 64'd1, 1'b1};
    vecs[6]  = '{c_add,   64'h0000_FFFF_0000_FFFF, 64'd1, 64'h0000_FFFF_0001_0000, 1'b0};
    vecs[7]  = '{c_cmpgt, 64'd7, 64'd5, 64'd1, 1'b1};
    vecs[8]  = '{c_cmpgt, 64'd1, c_min, 64'd1, 1'b1};
    vecs[9]  = '{c_cmphi, 64'd5, 64'd5, 64'd0, 1'b0};
    vecs[10] = '{c_cmphi, 64'd5, 64'd7, 64'd0, 1'b0};
    vecs[11] = '{c_cmpeq, 64'd1, 64'd2, 64'd0, 1'b0};
    vecs[12] = '{c_sub,   64'h1_0000_0000, 64'd1, 64'h0000_0000_FFFF_FFFF, 1'b0};
    vecs[13] = '{c_add,   64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
                 64'h2222_2222_2222_2211, 1'b0};

    tick();
    tick();
    chk("reset_valid", {63'd0, resValid}, 64'd0);
    chk("reset_val",   resVal, 64'd0);
    chk("reset_t",     {63'd0, resT}, 64'd0);
    chk("reset_carry", {63'd0, resCarry}, 64'd0);
    reset = 1'b0;
    tick();

    // Table: one op at a time, result checked two edges after issue
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].cmd, vecs[i].a, vecs[i].b);
      tick();
      drive(1'b0, c_nop, 64'd0, 64'd0);
      chk($sformatf("vec%0d_lat1_valid", i), {63'd0, resValid}, 64'd0);
      tick();
      chk($sformatf("vec%0d_valid", i), {63'd0, resValid}, 64'd1);
      chk($sformatf("vec%0d_val", i),   resVal, vecs[i].val);
      chk($sformatf("vec%0d_t", i),     {63'd0, resT}, {63'd0, vecs[i].t});
    end
    tick();
    chk("idle_valid", {63'd0, resValid}, 64'd0);

    // Back-to-back throughput
    drive(1'b1, c_add, 64'd1, 64'd2);
    tick();
    drive(1'b1, c_sub, 64'd10, 64'd3);
    tick();
    drive(1'b0, c_nop, 64'd0, 64'd0);
    chk("b2b_r1", resVal, 64'd3);
    tick();
    chk("b2b_r2", resVal, 64'd7);
    chk("b2b_r2_valid", {63'd0, resValid}, 64'd1);
    tick();
    chk("b2b_end_valid", {63'd0, resValid}, 64'd0);

    // 128-bit add via ADC chain (carry starts at 0)
`ifdef JX2_ALU_ADDCARRY_EN
    exp_r2 = 64'd1;
    exp_c1 = 64'd1;
`else
    exp_r2 = 64'd0;
    exp_c1 = 64'd0;
`endif
    drive(1'b1, c_adc, c_ones, 64'd1);
    tick();
    drive(1'b1, c_adc, 64'd0, 64'd0);
    tick();
    drive(1'b0, c_nop, 64'd0, 64'd0);
    chk("adc_lo", resVal, 64'd0);
    chk("adc_lo_carry", {63'd0, resCarry}, exp_c1);
    tick();
    chk("adc_hi", resVal, exp_r2);
    chk("adc_hi_carry", {63'd0, resCarry}, 64'd0);
    tick();

    // SBB chain
`ifdef JX2_ALU_ADDCARRY_EN
    exp_r2 = 64'd4;
`else
    exp_r2 = 64'd5;
`endif
    drive(1'b1, c_sbb, 64'd0, 64'd1);
    tick();
    drive(1'b1, c_sbb, 64'd5, 64'd0);
    tick();
    drive(1'b0, c_nop, 64'd0, 64'd0);
    chk("sbb1", resVal, c_ones);
    chk("sbb1_borrow", {63'd0, resCarry}, exp_c1);
    tick();
    chk("sbb2", resVal, exp_r2);
    chk("sbb2_borrow", {63'd0, resCarry}, 64'd0);
    tick();

    // Hold with two ops in flight; carry set to 1 first when present
    drive(1'b1, c_adc, c_ones, 64'd1);
    tick();
    drive(1'b1, c_add, 64'd100, 64'd1);
    tick();
    drive(1'b1, c_sub, 64'd50, 64'd8);
    tick();
    chk("hold_pre", resVal, 64'd101);
    exHold = 1'b1;
    drive(1'b1, c_add, 64'd999, 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold%0d_val", k), resVal, 64'd101);
      chk($sformatf("hold%0d_valid", k), {63'd0, resValid}, 64'd1);
      chk($sformatf("hold%0d_carry", k), {63'd0, resCarry}, exp_c1);
    end
    exHold = 1'b0;
    drive(1'b0, c_nop, 64'd0, 64'd0);
    tick();
    chk("hold_post_val", resVal, 64'd42);
    chk("hold_post_valid", {63'd0, resValid}, 64'd1);
    tick();
    chk("hold_drain_valid", {63'd0, resValid}, 64'd0);

    // Reset mid-flight: carry is 1 (when present) before reset
    drive(1'b1, c_adc, c_ones, 64'd1);
    tick();
    drive(1'b1, c_add, 64'd3, 64'd4);
    tick();
    drive(1'b1, c_adc, 64'd1, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, c_nop, 64'd0, 64'd0);
    chk("rst_mid_valid", {63'd0, resValid}, 64'd0);
    chk("rst_mid_val",   resVal, 64'd0);
    chk("rst_mid_carry", {63'd0, resCarry}, 64'd0);
    tick();
    chk("rst_flush_valid", {63'd0, resValid}, 64'd0);
    drive(1'b1, c_adc, 64'd0, 64'd0);
    tick();
    drive(1'b1, c_add, 64'd2, 64'd2);
    tick();
    drive(1'b0, c_nop, 64'd0, 64'd0);
    chk("post_rst_adc", resVal, 64'd0);
    chk("post_rst_adc_valid", {63'd0, resValid}, 64'd1);
    tick();
    chk("post_rst_add", resVal, 64'd4);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
